// File: rtl/loader_pkg.sv
// Shared types and constants for the frame-memory write path.
// The FSM states and word geometry live here so the loader and packer agree on them.
package loader_pkg;

    localparam int LOADER_ADDR_W     = 18;
    localparam int LOADER_WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        WRITE
    } loader_state_t;

endpackage

// File: rtl/byte_packer.sv
// Four-lane byte register that assembles a little-endian 32-bit word.
// Lane 0 lands in word[7:0], lane 3 in word[31:24]; clear wins over load.
module byte_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [1:0]  lane,
    input  logic [7:0]  lane_byte,
    input  logic        clear,
    output logic [31:0] word
);

    logic [LOADER_WORD_BYTES-1:0][7:0] lanes;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lanes <= '0;
        end else if (clear) begin
            lanes <= '0;
        end else if (load) begin
            lanes[lane] <= lane_byte;
        end
    end

    assign word = lanes;

endmodule

// File: rtl/image_word_loader.sv
// Packs a host byte stream into 32-bit words and writes NUM_WORDS of them
// into frame memory starting at BASE_ADDR; sole writer of that memory.
module image_word_loader
    import loader_pkg::*;
#(
    parameter int ADDR_W    = LOADER_ADDR_W,
    parameter int BASE_ADDR = 0,
    parameter int NUM_WORDS = 16384
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              wren,
    output logic [31:0]       data,
    output logic [ADDR_W-1:0] wraddress,
    output logic              busy,
    output logic              done
);

    localparam int                CNT_W = $clog2(NUM_WORDS + 1);
    localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(NUM_WORDS - 1);

    loader_state_t    state, state_next;
    logic [1:0]       byte_idx;
    logic [CNT_W-1:0] word_cnt;
    logic             accept;
    logic             start_ok;
    logic             abort_busy;
    logic             last_write;

    // in_ready is a flop that is high only in FILL, so a handshake implies FILL.
    assign accept     = in_valid && in_ready;
    assign start_ok   = (state == IDLE) && start && !abort;
    assign abort_busy = (state != IDLE) && abort;
    assign last_write = (state == WRITE) && (word_cnt == LAST);

    // NOTE: state_next gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_ok) state_next = FILL;
            FILL: begin
                if (abort)                            state_next = IDLE;
                else if (accept && byte_idx == 2'd3)  state_next = WRITE;
            end
            WRITE: begin
                if (abort || last_write) state_next = IDLE;
                else                     state_next = FILL;
            end
            default: state_next = IDLE;
        endcase
    end

    // Control outputs are decoded from the next state so they leave flops directly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            wren     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            in_ready <= (state_next == FILL);
            wren     <= (state_next == WRITE);
            busy     <= (state_next != IDLE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byte_idx  <= '0;
            word_cnt  <= '0;
            wraddress <= BASE;
            done      <= 1'b0;
        end else if (start_ok) begin
            byte_idx  <= '0;
            word_cnt  <= '0;
            wraddress <= BASE;
            done      <= 1'b0;
        end else begin
            if (accept) begin
                byte_idx <= byte_idx + 1'b1;
            end
            // wraddress tracks BASE + word_cnt incrementally; it is only meaningful while wren is high.
            if (state == WRITE) begin
                word_cnt  <= word_cnt + 1'b1;
                wraddress <= wraddress + 1'b1;
                if (last_write && !abort) begin
                    done <= 1'b1;
                end
            end
        end
    end

    // Clearing on start/abort drops any partial word; an abort in WRITE clears only after the write cycle.
    byte_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .load      (accept),
        .lane      (byte_idx),
        .lane_byte (in_data),
        .clear     (start_ok || abort_busy),
        .word      (data)
    );

endmodule

// File: tb/tb_image_word_loader.sv
// Self-checking bench: two loader instances (small 2-word load at 0x100, and a
// load covering a whole 8-bit address space) checked against a byte-stream model.
module tb_image_word_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort, in_valid, sel;
    logic [7:0]  in_data;

    logic        a_in_ready, a_wren, a_busy, a_done;
    logic [31:0] a_data;
    logic [17:0] a_wraddress;
    logic        f_in_ready, f_wren, f_busy, f_done;
    logic [31:0] f_data;
    logic [7:0]  f_wraddress;

    logic        rdy_o, wren_o, busy_o, done_o;
    logic [31:0] data_o;
    logic [17:0] wa_o;

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  src[$];
    logic [31:0] dut_mem[int];
    int          wr_count;
    int          last_wa;

    always #5 clk = ~clk;

    image_word_loader #(.ADDR_W(18), .BASE_ADDR('h100), .NUM_WORDS(2)) dut_a (
        .clk(clk), .reset(reset), .start(start & ~sel), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(a_in_ready),
        .wren(a_wren), .data(a_data), .wraddress(a_wraddress),
        .busy(a_busy), .done(a_done)
    );

    image_word_loader #(.ADDR_W(8), .BASE_ADDR(0), .NUM_WORDS(256)) dut_f (
        .clk(clk), .reset(reset), .start(start & sel), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(f_in_ready),
        .wren(f_wren), .data(f_data), .wraddress(f_wraddress),
        .busy(f_busy), .done(f_done)
    );

    always_comb begin
        rdy_o  = sel ? f_in_ready : a_in_ready;
        wren_o = sel ? f_wren     : a_wren;
        busy_o = sel ? f_busy     : a_busy;
        done_o = sel ? f_done     : a_done;
        data_o = sel ? f_data     : a_data;
        wa_o   = sel ? {10'd0, f_wraddress} : a_wraddress;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Little-endian word k of the source stream.
    function automatic logic [31:0] exp_word(input int k);
        return {src[4*k+3], src[4*k+2], src[4*k+1], src[4*k]};
    endfunction

    task automatic fill_src(input int n);
        src.delete();
        for (int i = 0; i < n; i++) src.push_back(8'($urandom));
    endtask

    // One load: gap = % of cycles with in_valid low, abort_at = accepted-byte
    // count at which abort is raised (-1 none), glitch = cycle of a stray start (-1 none).
    task automatic run_load(input bit s, input int nwords, input int base,
                            input int gap, input int abort_at, input int glitch);
        int  acc;
        bit  exp_wr;
        bit  finished;
        sel      = s;
        wr_count = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_after_start", busy_o, 1);
        check("ready_after_start", rdy_o, 1);
        check("done_cleared", done_o, 0);
        acc = 0; exp_wr = 1'b0; finished = 1'b0;
        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            check("wren_timing", wren_o, exp_wr);
            if (wren_o) begin
                check("wr_addr", wa_o, 64'(base + wr_count));
                check("wr_data", data_o, exp_word(wr_count));
                check("ready_low_in_write", rdy_o, 0);
                dut_mem[int'(wa_o)] = data_o;
                last_wa = int'(wa_o);
                wr_count++;
                if (wr_count == nwords) begin
                    in_valid = 1'b0; start = 1'b0;
                    @(negedge clk);
                    check("done_after_last", done_o, 1);
                    check("busy_after_last", busy_o, 0);
                    check("ready_after_last", rdy_o, 0);
                    finished = 1'b1;
                end
            end
            if (!finished) begin
                abort    = (abort_at >= 0) && (acc == abort_at);
                start    = (cyc == glitch);
                in_valid = !abort && (acc < nwords * 4) && ($urandom_range(99) >= gap);
                in_data  = in_valid ? src[acc] : 8'($urandom);
                exp_wr   = in_valid && rdy_o && ((acc + 1) % 4 == 0);
                if (in_valid && rdy_o) acc++;
                @(negedge clk);
                if (abort) begin
                    abort = 1'b0; start = 1'b0;
                    check("abort_busy", busy_o, 0);
                    check("abort_ready", rdy_o, 0);
                    check("abort_done", done_o, 0);
                    in_valid = 1'b1;
                    repeat (8) begin
                        @(negedge clk);
                        check("no_write_after_abort", wren_o, 0);
                    end
                    finished = 1'b1;
                end
            end
        end
        if (!finished) check("load_timeout", 0, 1);
        in_valid = 1'b0; start = 1'b0; abort = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = '0; sel = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_a_ready", a_in_ready, 0);
        check("rst_a_wren", a_wren, 0);
        check("rst_a_data", a_data, 0);
        check("rst_a_addr", a_wraddress, 'h100);
        check("rst_a_busy", a_busy, 0);
        check("rst_a_done", a_done, 0);
        check("rst_f_addr", f_wraddress, 0);
        check("rst_f_busy", f_busy, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Basic load with the reference byte sequence and no gaps.
        src = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        run_load(1'b0, 2, 'h100, 0, -1, -1);
        check("basic_word0", dut_mem['h100], 32'h44332211);
        check("basic_word1", dut_mem['h101], 32'h88776655);
        check("basic_count", wr_count, 2);

        // start and abort together in IDLE: nothing happens and done is held.
        @(negedge clk); start = 1'b1; abort = 1'b1;
        @(negedge clk); start = 1'b0; abort = 1'b0;
        check("start_abort_busy", busy_o, 0);
        check("start_abort_ready", rdy_o, 0);
        check("start_abort_done", done_o, 1);

        // Abort after two bytes of word 1, then abort during a WRITE cycle.
        fill_src(8);
        run_load(1'b0, 2, 'h100, 20, 6, -1);
        check("abort_mid_count", wr_count, 1);
        fill_src(8);
        run_load(1'b0, 2, 'h100, 0, 4, -1);
        check("abort_write_count", wr_count, 1);

        // Stray start while busy must not disturb addresses or count.
        fill_src(8);
        run_load(1'b0, 2, 'h100, 25, -1, 3);
        check("glitch_count", wr_count, 2);

        // Asynchronous reset in the middle of FILL.
        sel = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; in_valid = 1'b1; in_data = 8'hA5;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("async_rst_ready", a_in_ready, 0);
        check("async_rst_busy", a_busy, 0);
        check("async_rst_data", a_data, 0);
        check("async_rst_addr", a_wraddress, 'h100);
        check("async_rst_wren", a_wren, 0);
        check("async_rst_done", a_done, 0);
        @(negedge clk); reset = 1'b1; in_valid = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("post_rst_no_write", a_wren, 0);
            check("post_rst_idle", a_busy, 0);
        end
        in_valid = 1'b0;

        // Whole-address-space load with random gaps; compare the written memory.
        fill_src(1024);
        dut_mem.delete();
        run_load(1'b1, 256, 0, 30, -1, -1);
        check("full_count", wr_count, 256);
        check("full_last_addr", last_wa, 'hFF);
        check("full_mem_size", dut_mem.num(), 256);
        for (int k = 0; k < 256; k++) begin
            check("full_mem", dut_mem.exists(k) ? dut_mem[k] : 32'hDEAD_BEEF, exp_word(k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
